pipe_regfile: RTL and testbench
===============================

# pipe_regfile

Parametrised Y86-64 register file for the PIPE processor: two combinational read ports with write-through bypass, two write ports (E and M), and a per-register pending-write scoreboard. Decode reads `valA`/`valB` here and claims destinations. Writeback retires them. The `busyA`/`busyB` outputs feed the hazard/stall unit.

## Interface
- `DATA_W`, 64, register width in bits
- `ID_W`, 4, register-id width; id `2**ID_W-1` is RNONE
- `NREGS`, 15, architectural registers (ids 0..NREGS-1); must be ≤ `2**ID_W-1`
- `SP_ID`, 4, id of %rsp
- `SP_RESET`, 64'h0, reset value of %rsp (all other registers reset to 0)
- `PEND_W`, 2, scoreboard counter width; max in-flight writes per register = `2**PEND_W-1`

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `srcA`, `srcB`  in  ID_W  read addresses
- `valA`, `valB`  out  DATA_W  read data
- `busyA`, `busyB`  out  1  source has an outstanding claimed write
- `wb_en`  in  1  writeback stage valid; gates both writes and releases
- `dstE`, `dstM`  in  ID_W  write addresses (RNONE = no write)
- `valE`, `valM`  in  DATA_W  write data
- `claim_en`  in  1  decode issuing an instruction
- `claim_dstE`, `claim_dstM`  in  ID_W  destinations being claimed (RNONE = none)
- `err_ovf`, `err_unf`  out  1  sticky scoreboard overflow / underflow
- `dbg_sel`  in  ID_W, `dbg_val`  out  DATA_W  debug read port, no bypass

## Operation
- Read: `valX` is `valM` if `wb_en && srcX==dstM`, otherwise `valE` if `wb_en && srcX==dstE`, otherwise `regs[srcX]`. `srcX`=RNONE or ≥NREGS returns 0 and never bypasses.
- Write: on the clock edge with `wb_en`, `regs[dstE]<=valE` and `regs[dstM]<=valM`. If `dstE==dstM` (not RNONE), M wins (popq %rsp semantics). Ids ≥NREGS are ignored.
- Scoreboard: one `PEND_W`-bit counter per register, with next = cnt + claims − releases.
  - A claim is `claim_en && claim_dstE==r`, plus `claim_en && claim_dstM==r`. Both may hit the same register (+2).
  - A release is `wb_en && dstE==r`, plus `wb_en && dstM==r`.
  - A simultaneous claim and release on the same register nets out.
- `busyX` = `srcX` valid && `cnt[srcX]!=0` (registered count only; a same-cycle release does not clear it; the bypass supplies data).
- Overflow: if next would exceed `2**PEND_W-1`, the counter saturates at max and `err_ovf` is set.
- Underflow: if next would go below 0, the counter holds at 0 and `err_unf` is set.
- Both error flags stay set until `rst`.
- No state machine beyond the counters; the block never stalls itself.

## Timing
- Read latency is 0 (combinational from `src*`, `dst*`, `val*`, `wb_en`). A write is visible in `regs` from the cycle after the edge.
- Claim latency: `busy` rises the cycle after the claiming edge.
- Reset state, asynchronous on `rst` rise:
  - all registers 0, except `regs[SP_ID]=SP_RESET`;
  - all counters 0;
  - `err_*`=0, `busy*`=0;
  - `valA`/`valB`/`dbg_val` reflect the reset contents immediately.
- Reset mid-operation discards all pending claims and in-flight writes; the first edge after deassert behaves as a fresh start.

## Structure
- Shared package `y86_pkg`:
  - `RNONE`, `RSP`, and a register-id enum (RAX..R14);
  - default `DATA_W`;
  - icode constants used by the decode logic.
- Sub-module `regfile_scoreboard`: counter array, claim/release arithmetic, saturation and error flags, `busy` lookup.
- `pipe_regfile` holds the storage, the bypass muxes and the debug port.

## Test plan
- Reset with `SP_RESET=64'h100`: `dbg_sel=4` → `dbg_val`=0x100; `srcA=0` → `valA`=0; `busyA=busyB=0`, `err_*`=0.
- Write `dstE=2,valE=5` and `dstM=3,valM=7` with `wb_en=1`, `srcA=2`, `srcB=3` in the same cycle: `valA`=5 and `valB`=7 combinationally; after the edge, with `wb_en=0`, they still read 5 and 7.
- `dstE=dstM=4`, `valE=8`, `valM=9`, `wb_en=1`, `srcA=4`: `valA`=9, and `regs[4]`=9 after the edge.
- Claim `claim_dstE=6`, then next cycle `srcA=6`: `busyA`=1. Release via `dstE=6,wb_en=1`: `busyA`=1 that cycle, 0 the following cycle.
- Claim register 1 via both ports in one cycle (cnt=2), then claim once more (cnt=3), then claim again: cnt stays 3 and `err_ovf`=1. Release with cnt=0: `err_unf`=1. Both clear only on `rst`.
- Assert `rst` mid-cycle with cnt[5]=2 and `regs[5]`=0x55: counters and `regs[5]` read 0 before the next edge.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 definitions for the PIPE processor.
//   - Register ids (RAX..R14), RSP and RNONE
//   - Default datapath width
//   - Instruction codes used by the decode logic
package y86_pkg;

    localparam int unsigned DATA_W_DEF = 64;
    localparam int unsigned REG_ID_W   = 4;

    typedef enum logic [REG_ID_W-1:0] {
        RAX   = 4'h0,
        RCX   = 4'h1,
        RDX   = 4'h2,
        RBX   = 4'h3,
        RSPID = 4'h4,
        RBP   = 4'h5,
        RSI   = 4'h6,
        RDI   = 4'h7,
        R8    = 4'h8,
        R9    = 4'h9,
        R10   = 4'hA,
        R11   = 4'hB,
        R12   = 4'hC,
        R13   = 4'hD,
        R14   = 4'hE,
        RNONE_ID = 4'hF
    } reg_id_e;

    localparam logic [REG_ID_W-1:0] RSP   = 4'h4;
    localparam logic [REG_ID_W-1:0] RNONE = 4'hF;

    typedef enum logic [3:0] {
        IHALT   = 4'h0,
        INOP    = 4'h1,
        IRRMOVQ = 4'h2,
        IIRMOVQ = 4'h3,
        IRMMOVQ = 4'h4,
        IMRMOVQ = 4'h5,
        IOPQ    = 4'h6,
        IJXX    = 4'h7,
        ICALL   = 4'h8,
        IRET    = 4'h9,
        IPUSHQ  = 4'hA,
        IPOPQ   = 4'hB
    } icode_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write counters.
//   claim_en/claim_dstE/claim_dstM : decode claims destinations (+1 each)
//   wb_en/dstE/dstM                : writeback releases destinations (-1 each)
//   srcA/srcB -> busyA/busyB       : registered count of the source is nonzero
//   err_ovf/err_unf                : sticky saturation / underflow flags
module regfile_scoreboard
    import y86_pkg::*;
#(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned NREGS  = 15,
    parameter int unsigned PEND_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            claim_en,
    input  logic [ID_W-1:0] claim_dstE,
    input  logic [ID_W-1:0] claim_dstM,
    input  logic            wb_en,
    input  logic [ID_W-1:0] dstE,
    input  logic [ID_W-1:0] dstM,
    input  logic [ID_W-1:0] srcA,
    input  logic [ID_W-1:0] srcB,
    output logic            busyA,
    output logic            busyB,
    output logic            err_ovf,
    output logic            err_unf
);

    localparam int CNT_MAX = (1 << PEND_W) - 1;

    logic [PEND_W-1:0] cnt_q [NREGS];
    logic [PEND_W-1:0] cnt_d [NREGS];
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    int                nxt;

    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        nxt   = 0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            nxt = int'(cnt_q[r]);
            if (claim_en && claim_dstE == ID_W'(r)) nxt = nxt + 1;
            if (claim_en && claim_dstM == ID_W'(r)) nxt = nxt + 1;
            if (wb_en && dstE == ID_W'(r))          nxt = nxt - 1;
            if (wb_en && dstM == ID_W'(r))          nxt = nxt - 1;
            if (nxt > CNT_MAX) begin
                cnt_d[r] = PEND_W'(CNT_MAX);
                ovf_d    = 1'b1;
            end else if (nxt < 0) begin
                cnt_d[r] = '0;
                unf_d    = 1'b1;
            end else begin
                cnt_d[r] = PEND_W'(nxt);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREGS; r++) cnt_q[r] <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Ids at or above NREGS (including RNONE) never match, so they read not-busy.
    always_comb begin
        busyA = 1'b0;
        busyB = 1'b0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            if (srcA == ID_W'(r) && cnt_q[r] != '0) busyA = 1'b1;
            if (srcB == ID_W'(r) && cnt_q[r] != '0) busyB = 1'b1;
        end
    end

    assign err_ovf = ovf_q;
    assign err_unf = unf_q;

endmodule

// File: rtl/pipe_regfile.sv
// pipe_regfile: Y86-64 PIPE register file.
//   srcA/srcB -> valA/valB : combinational read with writeback bypass (M over E)
//   busyA/busyB            : source has an outstanding claimed write
//   wb_en, dstE/valE, dstM/valM : writeback ports; M wins on same destination
//   claim_en, claim_dstE/claim_dstM : decode destination claims
//   err_ovf/err_unf        : sticky scoreboard errors
//   dbg_sel -> dbg_val     : raw register contents, no bypass
module pipe_regfile
    import y86_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ID_W     = 4,
    parameter int unsigned NREGS    = 15,
    parameter int unsigned SP_ID    = 4,
    parameter logic [DATA_W-1:0] SP_RESET = '0,
    parameter int unsigned PEND_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   srcA,
    input  logic [ID_W-1:0]   srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic              busyA,
    output logic              busyB,
    input  logic              wb_en,
    input  logic [ID_W-1:0]   dstE,
    input  logic [ID_W-1:0]   dstM,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic              claim_en,
    input  logic [ID_W-1:0]   claim_dstE,
    input  logic [ID_W-1:0]   claim_dstM,
    output logic              err_ovf,
    output logic              err_unf,
    input  logic [ID_W-1:0]   dbg_sel,
    output logic [DATA_W-1:0] dbg_val
);

    logic [DATA_W-1:0] regs_q [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs_q[r] <= (r == SP_ID) ? SP_RESET : '0;
            end
        end else if (wb_en) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                if (dstM == ID_W'(r))      regs_q[r] <= valM;
                else if (dstE == ID_W'(r)) regs_q[r] <= valE;
            end
        end
    end

    // Bypass only applies to a valid source; an invalid id reads 0 even if
    // it equals an (ignored) RNONE destination.
    logic vldA, vldB;

    always_comb begin
        valA    = '0;
        valB    = '0;
        dbg_val = '0;
        vldA    = 1'b0;
        vldB    = 1'b0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            if (srcA == ID_W'(r)) begin
                valA = regs_q[r];
                vldA = 1'b1;
            end
            if (srcB == ID_W'(r)) begin
                valB = regs_q[r];
                vldB = 1'b1;
            end
            if (dbg_sel == ID_W'(r)) dbg_val = regs_q[r];
        end
        if (vldA && wb_en) begin
            if (srcA == dstM)      valA = valM;
            else if (srcA == dstE) valA = valE;
        end
        if (vldB && wb_en) begin
            if (srcB == dstM)      valB = valM;
            else if (srcB == dstE) valB = valE;
        end
    end

    regfile_scoreboard #(
        .ID_W   (ID_W),
        .NREGS  (NREGS),
        .PEND_W (PEND_W)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .claim_en   (claim_en),
        .claim_dstE (claim_dstE),
        .claim_dstM (claim_dstM),
        .wb_en      (wb_en),
        .dstE       (dstE),
        .dstM       (dstM),
        .srcA       (srcA),
        .srcB       (srcB),
        .busyA      (busyA),
        .busyB      (busyB),
        .err_ovf    (err_ovf),
        .err_unf    (err_unf)
    );

endmodule

// File: tb/tb_pipe_regfile.sv
// tb_pipe_regfile: directed self-checking bench for pipe_regfile.
module tb_pipe_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  srcA, srcB, dstE, dstM, claim_dstE, claim_dstM, dbg_sel;
    logic [63:0] valA, valB, valE, valM, dbg_val;
    logic        busyA, busyB, wb_en, claim_en, err_ovf, err_unf;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_regfile #(
        .DATA_W   (64),
        .ID_W     (4),
        .NREGS    (15),
        .SP_ID    (4),
        .SP_RESET (64'h100),
        .PEND_W   (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .srcA       (srcA),
        .srcB       (srcB),
        .valA       (valA),
        .valB       (valB),
        .busyA      (busyA),
        .busyB      (busyB),
        .wb_en      (wb_en),
        .dstE       (dstE),
        .dstM       (dstM),
        .valE       (valE),
        .valM       (valM),
        .claim_en   (claim_en),
        .claim_dstE (claim_dstE),
        .claim_dstM (claim_dstM),
        .err_ovf    (err_ovf),
        .err_unf    (err_unf),
        .dbg_sel    (dbg_sel),
        .dbg_val    (dbg_val)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, then settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_en = 1'b0; dstE = 4'hF; dstM = 4'hF; valE = '0; valM = '0;
        claim_en = 1'b0; claim_dstE = 4'hF; claim_dstM = 4'hF;
    endtask

    initial begin
        rst = 1'b1;
        srcA = 4'h0; srcB = 4'h0; dbg_sel = 4'h4;
        idle();
        #2;
        chk("rst_dbg_sp", dbg_val, 64'h100);
        chk("rst_valA0", valA, 64'h0);
        chk("rst_busyA", busyA, 1'b0);
        chk("rst_busyB", busyB, 1'b0);
        chk("rst_ovf", err_ovf, 1'b0);
        chk("rst_unf", err_unf, 1'b0);
        tick();
        rst = 1'b0;

        // Invalid source never bypasses
        srcA = 4'hF; wb_en = 1'b1; valE = 64'hAA; valM = 64'hBB;
        #1 chk("rnone_nobyp", valA, 64'h0);
        idle();
        tick();

        // Claim 2 and 3, then write them back
        claim_en = 1'b1; claim_dstE = 4'h2; claim_dstM = 4'h3;
        tick();
        idle();
        srcA = 4'h2; srcB = 4'h3;
        wb_en = 1'b1; dstE = 4'h2; valE = 64'h5; dstM = 4'h3; valM = 64'h7;
        #1;
        chk("byp_E_valA", valA, 64'h5);
        chk("byp_M_valB", valB, 64'h7);
        chk("busyA_2", busyA, 1'b1);
        chk("busyB_3", busyB, 1'b1);
        tick();
        idle();
        #1;
        chk("stored_valA", valA, 64'h5);
        chk("stored_valB", valB, 64'h7);
        chk("busyA_2_clr", busyA, 1'b0);
        chk("unf_clean", err_unf, 1'b0);

        // Same destination on both ports: M wins
        claim_en = 1'b1; claim_dstE = 4'h4; claim_dstM = 4'h4;
        tick();
        idle();
        srcA = 4'h4;
        wb_en = 1'b1; dstE = 4'h4; valE = 64'h8; dstM = 4'h4; valM = 64'h9;
        #1 chk("byp_Mwins", valA, 64'h9);
        tick();
        idle();
        #1;
        chk("stored_Mwins", valA, 64'h9);
        chk("dbg_r4", dbg_val, 64'h9);
        chk("busy_r4_clr", busyA, 1'b0);
        chk("unf_clean2", err_unf, 1'b0);

        // Claim latency and release timing
        srcA = 4'h6;
        claim_en = 1'b1; claim_dstE = 4'h6;
        #1 chk("busy6_before", busyA, 1'b0);
        tick();
        idle();
        #1 chk("busy6_claimed", busyA, 1'b1);
        wb_en = 1'b1; dstE = 4'h6; valE = 64'h66;
        #1;
        chk("busy6_relcyc", busyA, 1'b1);
        chk("byp6", valA, 64'h66);
        tick();
        idle();
        #1 chk("busy6_after", busyA, 1'b0);

        // Saturation at 3, then underflow
        srcB = 4'h1;
        claim_en = 1'b1; claim_dstE = 4'h1; claim_dstM = 4'h1;
        tick();
        #1 chk("busy1_cnt2", busyB, 1'b1);
        chk("ovf_cnt2", err_ovf, 1'b0);
        claim_dstM = 4'hF;
        tick();
        #1 chk("ovf_cnt3", err_ovf, 1'b0);
        tick();
        idle();
        #1 chk("ovf_set", err_ovf, 1'b1);
        wb_en = 1'b1; dstE = 4'h1;
        tick();
        tick();
        #1 chk("busy1_cnt1", busyB, 1'b1);
        tick();
        #1 chk("busy1_cnt0", busyB, 1'b0);
        chk("unf_at_sat", err_unf, 1'b0);
        tick();
        idle();
        #1 chk("unf_set", err_unf, 1'b1);
        chk("busy1_held0", busyB, 1'b0);
        tick(); tick();
        #1 chk("ovf_sticky", err_ovf, 1'b1);
        chk("unf_sticky", err_unf, 1'b1);

        // Mid-cycle reset with cnt[5]=2, regs[5]=0x55
        srcA = 4'h5; dbg_sel = 4'h5;
        claim_en = 1'b1; claim_dstE = 4'h5;
        tick();
        idle();
        claim_en = 1'b1; claim_dstE = 4'h5; claim_dstM = 4'h5;
        wb_en = 1'b1; dstE = 4'h5; valE = 64'h55;
        tick();
        idle();
        #1 chk("r5_written", dbg_val, 64'h55);
        chk("busy5_pre", busyA, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy5", busyA, 1'b0);
        chk("rst_r5", dbg_val, 64'h0);
        chk("rst_valA5", valA, 64'h0);
        chk("rst_ovf2", err_ovf, 1'b0);
        chk("rst_unf2", err_unf, 1'b0);
        dbg_sel = 4'h4;
        #1 chk("rst_sp2", dbg_val, 64'h100);
        tick();
        rst = 1'b0;
        tick();
        #1 chk("fresh_busy5", busyA, 1'b0);
        chk("fresh_unf", err_unf, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
